// File: rtl/conv_pool_engine_if.sv
// Memory/control bundle for conv_pool_engine.
// master: the engine (drives the memory strobes and status, takes start/pool_en/read data).
// slave : the environment (memory plus sequencer driving start/pool_en).
//   start, pool_en : run request and pooling mode, sampled when the engine is idle
//   read, write    : single-port byte memory strobes, never high together
//   addr           : memory address (AW bits)
//   mem_wdata      : write data (DW bits)
//   mem_rdata      : read data, valid the cycle after read
//   busy, done     : run in progress / one-cycle completion pulse
interface conv_pool_engine_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          start;
  logic          pool_en;
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;

  modport master (
    input  start, pool_en, mem_rdata,
    output read, write, addr, mem_wdata, busy, done
  );

  modport slave (
    output start, pool_en, mem_rdata,
    input  read, write, addr, mem_wdata, busy, done
  );
endinterface

// File: rtl/conv_pool_engine.sv
// KxK valid-mode convolution of an unsigned image with a signed kernel, both read from a
// shared single-port byte memory, followed by arithmetic right shift, clamp to [0, 2^DW-1]
// and optional 2x2/stride-2 max pooling. Results are written back row-major at OUT_BASE.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts a run without further memory access
//   bus : conv_pool_engine_if master side (start/pool_en in, memory strobes and status out)
module conv_pool_engine #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned K        = 3,
  parameter int unsigned IN_BASE  = 1,
  parameter int unsigned KER_BASE = 65,
  parameter int unsigned OUT_BASE = 128,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned ACCW     = 20
) (
  input logic                clk,
  input logic                rst,
  conv_pool_engine_if.master bus
);

  localparam int unsigned KK    = K * K;
  localparam int unsigned OH    = IMG_H - K + 1;
  localparam int unsigned OW    = IMG_W - K + 1;
  localparam int unsigned PH    = OH / 2;
  localparam int unsigned PW    = OW / 2;
  localparam int unsigned CntW  = $clog2(KK + 1);
  localparam int unsigned KW    = $clog2(K + 1);
  localparam int unsigned RW    = $clog2(IMG_H + 1);
  localparam int unsigned CW    = $clog2(IMG_W + 1);
  localparam int unsigned ProdW = 2 * DW + 1;
  localparam bit          PoolEmpty = (PH == 0) || (PW == 0);
  localparam logic signed [ACCW-1:0] YMax = ACCW'({DW{1'b1}});

  typedef enum logic [2:0] {
    StIdle,
    StLoadK,
    StConv,
    StPost,
    StWrite,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic                    pool_q, pool_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [KW-1:0]           ki_q, ki_d;
  logic [KW-1:0]           kj_q, kj_d;
  logic [RW-1:0]           out_r_q, out_r_d;
  logic [CW-1:0]           out_c_q, out_c_d;
  logic [1:0]              sub_q, sub_d;
  logic [AW-1:0]           out_idx_q, out_idx_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [DW-1:0]           res_q, res_d;
  // Weights live in a rotating register file: tap 0 is always at w_q[0], so the multiplier
  // needs no index mux. A full pass of K*K rotations restores the original order.
  logic signed [DW-1:0]    w_q [KK];
  logic signed [DW-1:0]    w_d [KK];

  logic [31:0]             conv_r, conv_c;
  logic signed [ProdW-1:0] prod;
  logic signed [ACCW-1:0]  shifted;
  logic [DW-1:0]           y;
  logic                    rd_phase;
  logic [CW-1:0]           last_c;
  logic [RW-1:0]           last_r;

  // Conv coordinate of the element being computed; in pool mode the output counters hold
  // the window index and sub_q selects the element inside the 2x2 window.
  always_comb begin
    if (pool_q) begin
      conv_r = (32'(out_r_q) << 1) + 32'(sub_q[1]);
      conv_c = (32'(out_c_q) << 1) + 32'(sub_q[0]);
      last_r = RW'(PH - 1);
      last_c = CW'(PW - 1);
    end else begin
      conv_r = 32'(out_r_q);
      conv_c = 32'(out_c_q);
      last_r = RW'(OH - 1);
      last_c = CW'(OW - 1);
    end
  end

  always_comb begin
    prod    = ProdW'($signed({1'b0, bus.mem_rdata})) * ProdW'(w_q[0]);
    shifted = acc_q >>> SHIFT;
    if (shifted[ACCW-1]) begin
      y = '0;
    end else if (shifted > YMax) begin
      y = {DW{1'b1}};
    end else begin
      y = shifted[DW-1:0];
    end
  end

  assign rd_phase = ((state_q == StLoadK) || (state_q == StConv)) && (cnt_q != CntW'(KK));

  always_comb begin
    state_d   = state_q;
    pool_d    = pool_q;
    cnt_d     = cnt_q;
    ki_d      = ki_q;
    kj_d      = kj_q;
    out_r_d   = out_r_q;
    out_c_d   = out_c_q;
    sub_d     = sub_q;
    out_idx_d = out_idx_q;
    acc_d     = acc_q;
    res_d     = res_q;
    w_d       = w_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d   = StLoadK;
          pool_d    = bus.pool_en;
          cnt_d     = '0;
          ki_d      = '0;
          kj_d      = '0;
          out_r_d   = '0;
          out_c_d   = '0;
          sub_d     = '0;
          out_idx_d = '0;
        end
      end

      StLoadK: begin
        // Data returning in cycle n>0 belongs to the read issued in cycle n-1.
        if (cnt_q != '0) begin
          for (int i = 0; i < int'(KK) - 1; i++) begin
            w_d[i] = w_q[i+1];
          end
          w_d[KK-1] = $signed(bus.mem_rdata);
        end
        if (cnt_q == CntW'(KK)) begin
          cnt_d   = '0;
          state_d = (pool_q && PoolEmpty) ? StDone : StConv;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StConv: begin
        if (cnt_q == '0) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q + ACCW'(prod);
          for (int i = 0; i < int'(KK) - 1; i++) begin
            w_d[i] = w_q[i+1];
          end
          w_d[KK-1] = w_q[0];
        end
        if (rd_phase) begin
          if (kj_q == KW'(K - 1)) begin
            kj_d = '0;
            ki_d = (ki_q == KW'(K - 1)) ? '0 : ki_q + KW'(1);
          end else begin
            kj_d = kj_q + KW'(1);
          end
        end
        if (cnt_q == CntW'(KK)) begin
          cnt_d   = '0;
          state_d = StPost;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StPost: begin
        if (!pool_q) begin
          res_d   = y;
          state_d = StWrite;
        end else begin
          // First element of a window loads directly, the rest keep the running max.
          if ((sub_q == 2'd0) || (y > res_q)) begin
            res_d = y;
          end
          sub_d   = sub_q + 2'd1;
          state_d = (sub_q == 2'd3) ? StWrite : StConv;
        end
      end

      StWrite: begin
        out_idx_d = out_idx_q + AW'(1);
        if (out_c_q == last_c) begin
          out_c_d = '0;
          if (out_r_q == last_r) begin
            state_d = StDone;
          end else begin
            out_r_d = out_r_q + RW'(1);
            state_d = StConv;
          end
        end else begin
          out_c_d = out_c_q + CW'(1);
          state_d = StConv;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    bus.read      = rd_phase;
    bus.write     = (state_q == StWrite);
    bus.busy      = (state_q != StIdle) && (state_q != StDone);
    bus.done      = (state_q == StDone);
    bus.addr      = '0;
    bus.mem_wdata = '0;
    if (rd_phase && (state_q == StLoadK)) begin
      bus.addr = AW'(KER_BASE + 32'(cnt_q));
    end else if (rd_phase) begin
      bus.addr = AW'(IN_BASE + (conv_r + 32'(ki_q)) * IMG_W + conv_c + 32'(kj_q));
    end else if (state_q == StWrite) begin
      bus.addr      = AW'(OUT_BASE) + out_idx_q;
      bus.mem_wdata = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pool_q    <= 1'b0;
      cnt_q     <= '0;
      ki_q      <= '0;
      kj_q      <= '0;
      out_r_q   <= '0;
      out_c_q   <= '0;
      sub_q     <= '0;
      out_idx_q <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      for (int i = 0; i < int'(KK); i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pool_q    <= pool_d;
      cnt_q     <= cnt_d;
      ki_q      <= ki_d;
      kj_q      <= kj_d;
      out_r_q   <= out_r_d;
      out_c_q   <= out_c_d;
      sub_q     <= sub_d;
      out_idx_q <= out_idx_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      for (int i = 0; i < int'(KK); i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Self-checking bench for conv_pool_engine. Two engines (SHIFT=0 and SHIFT=3) run in
// lockstep on identical memory images; every write is compared with a loop-based reference.
module tb_conv_pool_engine;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int KS = 3;
  localparam int OHc = IH - KS + 1;
  localparam int OWc = IW - KS + 1;

  logic clk;
  logic rst;

  conv_pool_engine_if #(.DW(8), .AW(8)) b0 ();
  conv_pool_engine_if #(.DW(8), .AW(8)) b1 ();

  conv_pool_engine #(.SHIFT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  conv_pool_engine #(.SHIFT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int         done_cnt0 = 0;
  int         done_cnt1 = 0;
  int         clash = 0;

  int pix [IH][IW];
  int ker [KS][KS];
  int exp0[$], exp1[$];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories: registered read, data valid one cycle after read.
  always @(posedge clk) begin
    if (b0.read) b0.mem_rdata <= mem0[b0.addr];
    if (b1.read) b1.mem_rdata <= mem1[b1.addr];
    if (b0.write) begin
      mem0[b0.addr] <= b0.mem_wdata;
      wa0.push_back(b0.addr);
      wd0.push_back(b0.mem_wdata);
    end
    if (b1.write) begin
      mem1[b1.addr] <= b1.mem_wdata;
      wa1.push_back(b1.addr);
      wd1.push_back(b1.mem_wdata);
    end
  end

  always @(negedge clk) begin
    if (b0.done) done_cnt0 <= done_cnt0 + 1;
    if (b1.done) done_cnt1 <= done_cnt1 + 1;
    if ((b0.read && b0.write) || (b1.read && b1.write)) clash <= clash + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clampy(input longint acc, input int sh);
    longint s;
    s = acc >>> sh;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  function automatic longint conv_at(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++)
        s += longint'(pix[r+i][c+j]) * longint'(ker[i][j]);
    return s;
  endfunction

  function automatic int out_at(input bit pool, input int r, input int c, input int sh);
    int m = 0;
    if (!pool) return clampy(conv_at(r, c), sh);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        if (clampy(conv_at(2*r+a, 2*c+b), sh) > m) m = clampy(conv_at(2*r+a, 2*c+b), sh);
    return m;
  endfunction

  task automatic build_expected(input bit pool);
    int nr, nc;
    exp0.delete();
    exp1.delete();
    nr = pool ? OHc / 2 : OHc;
    nc = pool ? OWc / 2 : OWc;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        exp0.push_back(out_at(pool, r, c, 0));
        exp1.push_back(out_at(pool, r, c, 3));
      end
  endtask

  task automatic load_mem();
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        mem0[1 + r*IW + c] <= 8'(pix[r][c]);
        mem1[1 + r*IW + c] <= 8'(pix[r][c]);
      end
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++) begin
        mem0[65 + i*KS + j] <= 8'(ker[i][j]);
        mem1[65 + i*KS + j] <= 8'(ker[i][j]);
      end
    @(negedge clk);
  endtask

  task automatic set_start(input logic s, input logic p);
    b0.start = s;
    b1.start = s;
    b0.pool_en = p;
    b1.pool_en = p;
  endtask

  task automatic run_and_check(input bit pool, input string tag, input bit extra_start,
                               output int wb);
    int wb1, db0, db1, n;
    wb  = wa0.size();
    wb1 = wa1.size();
    db0 = done_cnt0;
    db1 = done_cnt1;
    build_expected(pool);
    set_start(1'b1, pool);
    @(negedge clk);
    set_start(1'b0, ~pool);   // pool_en must have been latched at start
    check({tag, "_busy"}, {31'd0, b0.busy}, 32'd1);
    n = 0;
    while (!b0.done && n < 6000) begin
      @(negedge clk);
      n++;
      if (extra_start && (n == 20 || n == 200)) set_start(1'b1, pool);
      else set_start(1'b0, ~pool);
    end
    set_start(1'b0, 1'b0);
    check({tag, "_done_seen"}, {31'd0, b0.done}, 32'd1);
    check({tag, "_done_sync"}, {31'd0, b1.done}, {31'd0, b0.done});
    check({tag, "_busy_at_done"}, {31'd0, b0.busy}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_count0"}, done_cnt0 - db0, 32'd1);
    check({tag, "_done_count1"}, done_cnt1 - db1, 32'd1);
    check({tag, "_wcount0"}, wa0.size() - wb, exp0.size());
    check({tag, "_wcount1"}, wa1.size() - wb1, exp1.size());
    for (int i = 0; i < exp0.size(); i++) begin
      check({tag, "_addr0"}, {24'd0, wa0[wb + i]}, 128 + i);
      check({tag, "_data0"}, {24'd0, wd0[wb + i]}, exp0[i]);
      check({tag, "_addr1"}, {24'd0, wa1[wb1 + i]}, 128 + i);
      check({tag, "_data1"}, {24'd0, wd1[wb1 + i]}, exp1[i]);
    end
  endtask

  int wb;
  int pool_vals [9] = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
  int db0, wsz;

  initial begin
    rst = 1'b1;
    set_start(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_read", {31'd0, b0.read}, 32'd0);
    check("rst_write", {31'd0, b0.write}, 32'd0);
    check("rst_busy", {31'd0, b0.busy}, 32'd0);
    check("rst_done", {31'd0, b0.done}, 32'd0);
    check("rst_addr", {24'd0, b0.addr}, 32'd0);
    check("rst_wdata", {24'd0, b0.mem_wdata}, 32'd0);
    check("rst_busy1", {31'd0, b1.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Identity kernel on a ramp image.
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) pix[r][c] = 8*r + c;
    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) ker[i][j] = 0;
    ker[1][1] = 1;
    load_mem();
    run_and_check(1'b0, "ident", 1'b0, wb);
    check("ident_first", {24'd0, wd0[wb]}, 32'd9);
    check("ident_last", {24'd0, wd0[wb + 35]}, 32'd54);
    run_and_check(1'b1, "ident_pool", 1'b0, wb);
    for (int i = 0; i < 9; i++) check("ident_pool_val", {24'd0, wd0[wb + i]}, pool_vals[i]);

    // Constant image, all-ones kernel: 90 unshifted, 11 with SHIFT=3.
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) pix[r][c] = 10;
    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) ker[i][j] = 1;
    load_mem();
    run_and_check(1'b0, "const", 1'b0, wb);
    check("const_shift3", {24'd0, wd1[wb]}, 32'd11);
    check("const_shift0", {24'd0, wd0[wb]}, 32'd90);

    // Saturation high and clamp to zero.
    for (int r = 0; r < IH; r++) for (int c = 0; c < IW; c++) pix[r][c] = 255;
    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) ker[i][j] = 127;
    load_mem();
    run_and_check(1'b0, "sat", 1'b0, wb);
    check("sat_val", {24'd0, wd0[wb + 7]}, 32'd255);
    for (int i = 0; i < KS; i++) for (int j = 0; j < KS; j++) ker[i][j] = 0;
    ker[1][1] = -1;
    load_mem();
    run_and_check(1'b1, "neg", 1'b0, wb);
    check("neg_val", {24'd0, wd0[wb + 4]}, 32'd0);

    // Randomized images and kernels, both modes.
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < IH; r++)
        for (int c = 0; c < IW; c++)
          pix[r][c] = (t < 3) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 255));
      for (int i = 0; i < KS; i++)
        for (int j = 0; j < KS; j++)
          ker[i][j] = (t < 3) ? int'($urandom_range(0, 6)) - 2 : int'($urandom_range(0, 255)) - 128;
      load_mem();
      run_and_check(t[0], "rand", 1'b0, wb);
    end

    // Reset mid-CONV: everything idles immediately, no writes or done follow.
    set_start(1'b1, 1'b0);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    repeat (15) @(negedge clk);
    check("mid_busy", {31'd0, b0.busy}, 32'd1);
    db0 = done_cnt0;
    wsz = wa0.size();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_read", {31'd0, b0.read}, 32'd0);
    check("abort_write", {31'd0, b0.write}, 32'd0);
    check("abort_busy", {31'd0, b0.busy}, 32'd0);
    check("abort_busy1", {31'd0, b1.busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_done", done_cnt0 - db0, 32'd0);
    check("abort_no_write", wa0.size() - wsz, 32'd0);
    run_and_check(1'b0, "after_abort", 1'b0, wb);

    // start while busy is ignored: one run, one done.
    run_and_check(1'b1, "restart", 1'b1, wb);

    check("no_rw_clash", clash, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_pool_engine.md
Name: conv_pool_engine

Overview:
- Parametrised successor to the fixed 8x8 conv/pool block.
- Reads a kernel and an unsigned image from the shared single-port byte memory (same read/addr/write handshake style).
- Computes a valid-mode KxK signed convolution, then post-scales, clamps, and optionally 2x2 max-pools the result.
- Writes the results back to memory. Start/done handshake lets the top level sequence several layers.

Parameters:
- DW, 8, data width of pixels, weights and outputs.
- AW, 8, memory address width.
- IMG_W, 8, image width in pixels.
- IMG_H, 8, image height in pixels.
- K, 3, kernel size (KxK), 1 <= K <= min(IMG_W, IMG_H).
- IN_BASE, 1, address of pixel (0,0); image is row-major.
- KER_BASE, 65, address of weight (0,0); weights are row-major, signed.
- OUT_BASE, 128, address of first output, row-major.
- SHIFT, 0, arithmetic right shift applied to the accumulator.
- ACCW, 20, accumulator width; must hold K*K*(2^DW-1)*2^(DW-1) signed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a run when idle.
- pool_en  in  1  sampled at accepted start; 1 = 2x2/stride-2 max pool, 0 = write every conv output.
- read  out  1  memory read strobe.
- write  out  1  memory write strobe.
- addr  out  AW  memory address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data; valid the cycle after read=1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset (synchronous, active-high):
  - Next edge forces state IDLE; read, write, busy and done = 0; addr and mem_wdata = 0.
  - All counters, accumulator, kernel register file and pool max are cleared.
  - Reset mid-run aborts with no further memory access; no done pulse is issued.
- Memory access:
  - read and write are never high in the same cycle.
  - Reads are issued back-to-back, one address per cycle; the data consumed in cycle t+1 belongs to the address of cycle t.
- States:
  - IDLE: start=1 -> LOAD_K; latch pool_en; busy=1. start while busy is ignored.
  - LOAD_K: issue K*K reads KER_BASE..KER_BASE+K*K-1 and capture into the weight regs; 1 drain cycle (K*K+1 cycles) -> CONV.
  - CONV: for conv output (r,c), r in 0..IMG_H-K and c in 0..IMG_W-K:
    - Clear acc.
    - Read pixel IN_BASE+(r+i)*IMG_W+(c+j) for i,j in kernel order.
    - acc += zero-extended pixel * sign-extended weight.
    - K*K+1 cycles -> POST.
  - POST (1 cycle): y = acc >>> SHIFT, clamped to [0, 2^DW-1].
    - pool_en=0: -> WRITE.
    - pool_en=1: max register updated with y (first element of a window loads directly). Conv outputs are visited window by window in order (2R,2C), (2R,2C+1), (2R+1,2C), (2R+1,2C+1). After the 4th element -> WRITE, else -> CONV.
  - WRITE (1 cycle): write=1, addr=OUT_BASE+out_idx, mem_wdata=value; out_idx++.
    - More outputs -> CONV, else -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Output count:
  - Conv dimensions: OH = IMG_H-K+1, OW = IMG_W-K+1.
  - pool_en=0: OH*OW outputs.
  - pool_en=1: floor(OH/2)*floor(OW/2) outputs; odd last row/column is skipped (never read, never computed).
- Addresses wrap modulo 2^AW. Overlapping regions are not checked.
- Accumulation is full-precision in ACCW bits with no intermediate saturation.

Test Plan:
- Identity kernel (centre=1, rest 0), SHIFT=0, pool_en=0, ramp image pixel(r,c)=8r+c: 36 writes, OUT_BASE+6r+c = 8(r+1)+(c+1), e.g. first 9, last 54; then one done pulse.
- Same image and kernel, pool_en=1: 9 writes, values 18,20,22,34,36,38,50,52,54 at 128..136.
- Constant image 10, all-ones kernel, SHIFT=3: every output = 90>>>3 = 11.
- Saturation and clamp:
  - Image all 255, kernel all 127, SHIFT=0 -> every output 255.
  - Kernel centre=-1 -> every output 0.
- Reset asserted for 1 cycle mid-CONV: next cycle read=write=busy=0 with no done pulse. A following start runs to completion with correct outputs.
- start pulsed while busy: ignored, single run and single done. Bench checker flags any cycle with read&write=1.
